mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath: PC/NPC, IR, RF, EXT, ALU and dm_4k.
- Replaces single-cycle decode; datapath adds IR, A/B/ALUOut/MDR latches and AluSrcA mux.
- Decodes latched Op/Funct and emits per-state Moore strobes.
- Handles data-memory wait-states via mem_rdy, retired-instruction counting and illegal-opcode/timeout trapping.

Parameters:
CNT_W, 32, width of retired-instruction counter
WAIT_MAX, 15, max consecutive wait cycles on data memory before timeout trap (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_rdy  in  1  dm_4k access complete
PCWr  out  1  PC load enable
IRWr  out  1  IR load enable
RegW  out  1  RF write enable
RegDst  out  1  0=rd, 1=rt
Mem2R  out  1  1=RF write data from MDR
MemR  out  1  data-memory read request
MemW  out  1  data-memory write request
AluSrcA  out  1  0=PC, 1=RD1 latch
AluSrc  out  2  00=RD2, 01=const 4, 10=Imm32
ALUOp  out  2  00 ADD, 01 SUB, 10 OR, 11 SLT
ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
NPCOp  out  2  00 PC+4, 01 branch (PC+Imm32<<2), 10 jump (PC[31:28],IMM,00)
state_o  out  4  current state, debug
illegal  out  1  trap flag, sticky
err_code  out  2  00 none, 01 bad opcode/funct, 10 memory timeout
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- rst sampled on clk rising edge only.
  - While rst==0: state<=FETCH, instr_cnt<=0, illegal<=0, err_code<=0, wait_cnt<=0.
  - All write strobes (PCWr, IRWr, RegW, MemR, MemW) forced 0 while rst==0, including a reset mid-instruction; other outputs are don't-care.
- State encoding (shared package): FETCH 0, DCD 1, MA 2, MRD 3, MWR 4, WBM 5, EXR 6, WBR 7, EXI 8, WBI 9, BR 10, JMP 11, ILL 15.
- FETCH:
  - IRWr=1, PCWr=1, NPCOp=00, AluSrcA=0, AluSrc=01, ALUOp=00.
  - -> DCD.
- DCD: no strobes; decode Op/Funct.
  - Op 000000 with Funct addu 100001, subu 100011, or 100101, slt 101010 -> EXR.
  - lw 100011 / sw 101011 -> MA.
  - ori 001101 / addiu 001001 / lui 001111 -> EXI.
  - beq 000100 -> BR.
  - j 000010 -> JMP.
  - Anything else -> ILL with err_code=01.
- EXR: AluSrcA=1, AluSrc=00, ALUOp from Funct -> WBR.
- WBR: RegW=1, RegDst=0, Mem2R=0 -> FETCH.
- EXI: AluSrcA=1, AluSrc=10.
  - ori: ExtOp=00, ALUOp=10.
  - addiu: ExtOp=01, ALUOp=00.
  - lui: ExtOp=10, ALUOp=10, with AluSrcA forced to zero source.
  - -> WBI.
- WBI: RegW=1, RegDst=1 -> FETCH.
- MA: ExtOp=01, AluSrcA=1, AluSrc=10, ALUOp=00 -> MRD (lw) or MWR (sw).
- MRD/MWR: MemR or MemW held high every cycle in state.
  - mem_rdy=1: MRD -> WBM; MWR -> FETCH. wait_cnt cleared.
  - mem_rdy=0: stay, wait_cnt++.
  - If wait_cnt==WAIT_MAX and mem_rdy still 0: -> ILL, err_code=10, strobes dropped that cycle.
  - mem_rdy outside MRD/MWR is ignored.
- WBM: RegW=1, RegDst=1, Mem2R=1 -> FETCH.
- BR: AluSrcA=1, AluSrc=00, ALUOp=01, NPCOp=01, PCWr=zero -> FETCH.
  - PC already holds PC+4 from FETCH.
- JMP: NPCOp=10, PCWr=1 -> FETCH.
- ILL: all strobes 0, illegal=1; terminal until reset.
- instr_cnt increments by 1 on every transition into FETCH from a non-reset, non-ILL state; wraps modulo 2^CNT_W.
- Latency with mem_rdy immediate:
  - R-type/I-type ALU: 4 cycles.
  - lw: 5 cycles; sw: 4 cycles.
  - beq, j: 3 cycles.
  - Each wait cycle adds 1.
- Strobes are pure Moore decode of state plus Op/Funct; Op/Funct are stable from IR after FETCH.

Decomposition:
- Shared package/include (extends ctrl_encode_def.v / instruction_def.v):
  - state codes;
  - opcode/funct constants;
  - ALUOp, ExtOp, NPCOp, AluSrc, err_code encodings.
- One sub-module, mc_decode: combinational Op/Funct -> instruction class (R_ALU, IMM, LD, ST, BEQ, JMP, BAD) and ALUOp/ExtOp.
- mc_ctrl holds the FSM, wait counter and instr_cnt.

Test Plan:
- rst=0 for 3 cycles, then 1 -> during reset PCWr=IRWr=RegW=MemW=0; first cycle after release state_o=0, IRWr=1; instr_cnt=0.
- addu (Op 0, Funct 100001) -> states 0,1,6,7; RegW=1 only in cycle 4, RegDst=0; instr_cnt=1 after return to FETCH.
- lw with mem_rdy low 3 cycles then high -> states 0,1,2,3,3,3,3,5; MemR high all 4 MRD cycles; Mem2R=1, RegW=1 in WBM; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> PCWr=1 with NPCOp=01 in BR for the first; PCWr=0 for the second; 3 cycles each.
- Op=111111 -> after DCD, state_o=15, illegal=1, err_code=01; stays there 20 cycles with no strobes; rst=0 clears.
- sw with mem_rdy held 0, WAIT_MAX=15 -> MemW high for 16 MWR cycles, then ILL with err_code=10; instr_cnt not incremented.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcode/funct
// constants and the datapath select encodings driven by mc_ctrl.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MRD   = 4'd3,
    S_MWR   = 4'd4,
    S_WBM   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_EXI   = 4'd8,
    S_WBI   = 4'd9,
    S_BR    = 4'd10,
    S_JMP   = 4'd11,
    S_ILL   = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    C_R_ALU,
    C_IMM,
    C_LD,
    C_ST,
    C_BEQ,
    C_JMP,
    C_BAD
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_RD2  = 2'b00;
  localparam logic [1:0] SRC_FOUR = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: latched Op/Funct to instruction class
// plus the ALU operation and immediate extension used by the execute states.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output iclass_t    iclass,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op
);

  always_comb begin
    iclass = C_BAD;
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    unique case (Op)
      OP_RTYPE: begin
        iclass = C_R_ALU;
        case (Funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: iclass = C_BAD;
        endcase
      end
      OP_ORI:   begin iclass = C_IMM; alu_op = ALU_OR;  ext_op = EXT_ZERO; end
      OP_ADDIU: begin iclass = C_IMM; alu_op = ALU_ADD; ext_op = EXT_SIGN; end
      OP_LUI:   begin iclass = C_IMM; alu_op = ALU_OR;  ext_op = EXT_LUI;  end
      OP_LW:    iclass = C_LD;
      OP_SW:    iclass = C_ST;
      OP_BEQ:   iclass = C_BEQ;
      OP_J:     iclass = C_JMP;
      default:  iclass = C_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath: Moore strobes per state, data
// memory wait handling with timeout trap, and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegW,
  output logic             RegDst,
  output logic             Mem2R,
  output logic             MemR,
  output logic             MemW,
  output logic             AluSrcA,
  output logic [1:0]       AluSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic [1:0]       NPCOp,
  output logic [3:0]       state_o,
  output logic             illegal,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  iclass_t    iclass;
  logic [1:0] dec_alu_op, dec_ext_op;
  logic [7:0] wait_cnt;
  logic       in_mem, mem_timeout;

  mc_decode u_decode (
    .Op     (Op),
    .Funct  (Funct),
    .iclass (iclass),
    .alu_op (dec_alu_op),
    .ext_op (dec_ext_op)
  );

  assign in_mem      = (state == S_MRD) || (state == S_MWR);
  assign mem_timeout = in_mem && !mem_rdy && (wait_cnt == WAIT_LIM);
  assign state_o     = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
      illegal   <= 1'b0;
      err_code  <= ERR_NONE;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // ILL never leaves without reset, so any entry into FETCH retires an instruction
      if (state_nxt == S_FETCH)
        instr_cnt <= instr_cnt + CNT_W'(1);
      if (state_nxt == S_ILL && state != S_ILL) begin
        illegal  <= 1'b1;
        err_code <= (state == S_DCD) ? ERR_OPCODE : ERR_TIMEOUT;
      end
      if (in_mem && !mem_rdy)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: state_nxt = S_DCD;
      S_DCD: begin
        case (iclass)
          C_R_ALU: state_nxt = S_EXR;
          C_IMM:   state_nxt = S_EXI;
          C_LD,
          C_ST:    state_nxt = S_MA;
          C_BEQ:   state_nxt = S_BR;
          C_JMP:   state_nxt = S_JMP;
          default: state_nxt = S_ILL;
        endcase
      end
      S_MA:  state_nxt = (iclass == C_LD) ? S_MRD : S_MWR;
      S_MRD: state_nxt = mem_rdy ? S_WBM : (mem_timeout ? S_ILL : S_MRD);
      S_MWR: state_nxt = mem_rdy ? S_FETCH : (mem_timeout ? S_ILL : S_MWR);
      S_EXR: state_nxt = S_WBR;
      S_EXI: state_nxt = S_WBI;
      S_WBM, S_WBR, S_WBI, S_BR, S_JMP: state_nxt = S_FETCH;
      S_ILL: state_nxt = S_ILL;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RegW    = 1'b0;
    RegDst  = 1'b0;
    Mem2R   = 1'b0;
    MemR    = 1'b0;
    MemW    = 1'b0;
    AluSrcA = 1'b0;
    AluSrc  = SRC_RD2;
    ALUOp   = ALU_ADD;
    ExtOp   = EXT_ZERO;
    NPCOp   = NPC_PLUS4;
    unique case (state)
      S_FETCH: begin
        IRWr = 1'b1; PCWr = 1'b1; AluSrc = SRC_FOUR;
      end
      S_EXR: begin
        AluSrcA = 1'b1; AluSrc = SRC_RD2; ALUOp = dec_alu_op;
      end
      S_WBR: RegW = 1'b1;
      // lui encodes rs=$zero, so the RD1 latch already supplies the zero operand
      S_EXI: begin
        AluSrcA = 1'b1; AluSrc = SRC_IMM; ALUOp = dec_alu_op; ExtOp = dec_ext_op;
      end
      S_WBI: begin RegW = 1'b1; RegDst = 1'b1; end
      S_MA: begin
        AluSrcA = 1'b1; AluSrc = SRC_IMM; ALUOp = ALU_ADD; ExtOp = EXT_SIGN;
      end
      S_MRD: MemR = 1'b1;
      S_MWR: MemW = 1'b1;
      S_WBM: begin RegW = 1'b1; RegDst = 1'b1; Mem2R = 1'b1; end
      S_BR: begin
        AluSrcA = 1'b1; AluSrc = SRC_RD2; ALUOp = ALU_SUB;
        NPCOp = NPC_BRANCH; PCWr = zero;
      end
      S_JMP: begin NPCOp = NPC_JUMP; PCWr = 1'b1; end
      default: ;
    endcase
    // Reset is synchronous, so the state may still be mid-instruction here
    if (!rst) begin
      PCWr = 1'b0;
      IRWr = 1'b0;
      RegW = 1'b0;
      MemR = 1'b0;
      MemW = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, hand-written reset and
// trap sequences, then random instruction streams against a per-instruction trace model.
module tb_mc_ctrl;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 15;

  localparam logic [6:0] CARE_RD   = 7'b0000001;
  localparam logic [6:0] CARE_M2R  = 7'b0000010;
  localparam logic [6:0] CARE_SRCA = 7'b0000100;
  localparam logic [6:0] CARE_SRC  = 7'b0001000;
  localparam logic [6:0] CARE_ALU  = 7'b0010000;
  localparam logic [6:0] CARE_EXT  = 7'b0100000;
  localparam logic [6:0] CARE_NPC  = 7'b1000000;

  typedef struct {
    logic [3:0] st;
    logic       pcwr, irwr, regw, memr, memw;
    logic       regdst, mem2r, alusrca;
    logic [1:0] alusrc, aluop, extop, npcop;
    logic [6:0] care;
  } rec_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         waits;
    int         exp_cycles;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       Op, Funct;
  logic             zero, mem_rdy;
  logic             PCWr, IRWr, RegW, RegDst, Mem2R, MemR, MemW, AluSrcA;
  logic [1:0]       AluSrc, ALUOp, ExtOp, NPCOp, err_code;
  logic [3:0]       state_o;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  int   nTests = 0;
  int   nFail  = 0;
  int   modelCnt = 0;
  rec_t expQ[$];
  bit   expIll;
  logic [1:0] expErr;
  vec_t vecs[$];

  mc_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .RegW(RegW), .RegDst(RegDst), .Mem2R(Mem2R),
    .MemR(MemR), .MemW(MemW), .AluSrcA(AluSrcA), .AluSrc(AluSrc), .ALUOp(ALUOp),
    .ExtOp(ExtOp), .NPCOp(NPCOp), .state_o(state_o), .illegal(illegal),
    .err_code(err_code), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t blank(input logic [3:0] st);
    rec_t r;
    r = '{st: st, pcwr: 0, irwr: 0, regw: 0, memr: 0, memw: 0, regdst: 0, mem2r: 0,
          alusrca: 0, alusrc: 0, aluop: 0, extop: 0, npcop: 0, care: 0};
    return r;
  endfunction

  // Expected per-cycle trace of one instruction, built from the state-by-state rules
  task automatic buildTrace(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
    rec_t r;
    int   nMem;
    expQ.delete();
    expIll = 0;
    expErr = 2'b00;
    r = blank(4'd0);
    r.pcwr = 1; r.irwr = 1; r.alusrc = 2'b01;
    r.care = CARE_SRCA | CARE_SRC | CARE_ALU | CARE_NPC;
    expQ.push_back(r);
    expQ.push_back(blank(4'd1));
    if (op == 6'b000000 && (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100101 || fn == 6'b101010)) begin
      r = blank(4'd6);
      r.alusrca = 1;
      r.aluop = (fn == 6'b100001) ? 2'b00 : (fn == 6'b100011) ? 2'b01 : (fn == 6'b100101) ? 2'b10 : 2'b11;
      r.care = CARE_SRCA | CARE_SRC | CARE_ALU;
      expQ.push_back(r);
      r = blank(4'd7);
      r.regw = 1;
      r.care = CARE_RD | CARE_M2R;
      expQ.push_back(r);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      r = blank(4'd2);
      r.extop = 2'b01; r.alusrca = 1; r.alusrc = 2'b10;
      r.care = CARE_EXT | CARE_SRCA | CARE_SRC | CARE_ALU;
      expQ.push_back(r);
      nMem = (waits > WAIT_MAX) ? WAIT_MAX + 1 : waits + 1;
      for (int i = 0; i < nMem; i++) begin
        r = blank((op == 6'b100011) ? 4'd3 : 4'd4);
        r.memr = (op == 6'b100011);
        r.memw = (op == 6'b101011);
        expQ.push_back(r);
      end
      if (waits > WAIT_MAX) begin
        expIll = 1;
        expErr = 2'b10;
      end else if (op == 6'b100011) begin
        r = blank(4'd5);
        r.regw = 1; r.regdst = 1; r.mem2r = 1;
        r.care = CARE_RD | CARE_M2R;
        expQ.push_back(r);
      end
    end else if (op == 6'b001101 || op == 6'b001001 || op == 6'b001111) begin
      r = blank(4'd8);
      r.alusrca = 1; r.alusrc = 2'b10;
      r.extop = (op == 6'b001101) ? 2'b00 : (op == 6'b001001) ? 2'b01 : 2'b10;
      r.aluop = (op == 6'b001001) ? 2'b00 : 2'b10;
      r.care = CARE_SRCA | CARE_SRC | CARE_ALU | CARE_EXT;
      expQ.push_back(r);
      r = blank(4'd9);
      r.regw = 1; r.regdst = 1;
      r.care = CARE_RD;
      expQ.push_back(r);
    end else if (op == 6'b000100) begin
      r = blank(4'd10);
      r.alusrca = 1; r.aluop = 2'b01; r.npcop = 2'b01; r.pcwr = z;
      r.care = CARE_SRCA | CARE_SRC | CARE_ALU | CARE_NPC;
      expQ.push_back(r);
    end else if (op == 6'b000010) begin
      r = blank(4'd11);
      r.npcop = 2'b10; r.pcwr = 1;
      r.care = CARE_NPC;
      expQ.push_back(r);
    end else begin
      expIll = 1;
      expErr = 2'b01;
    end
  endtask

  task automatic compareRec(input string name, input int cyc, input rec_t r);
    string p;
    p = $sformatf("%s.c%0d", name, cyc);
    checkOutput({p, ".state"}, 32'(state_o), 32'(r.st));
    checkOutput({p, ".PCWr"},  32'(PCWr),  32'(r.pcwr));
    checkOutput({p, ".IRWr"},  32'(IRWr),  32'(r.irwr));
    checkOutput({p, ".RegW"},  32'(RegW),  32'(r.regw));
    checkOutput({p, ".MemR"},  32'(MemR),  32'(r.memr));
    checkOutput({p, ".MemW"},  32'(MemW),  32'(r.memw));
    if ((r.care & CARE_RD) != 0)   checkOutput({p, ".RegDst"},  32'(RegDst),  32'(r.regdst));
    if ((r.care & CARE_M2R) != 0)  checkOutput({p, ".Mem2R"},   32'(Mem2R),   32'(r.mem2r));
    if ((r.care & CARE_SRCA) != 0) checkOutput({p, ".AluSrcA"}, 32'(AluSrcA), 32'(r.alusrca));
    if ((r.care & CARE_SRC) != 0)  checkOutput({p, ".AluSrc"},  32'(AluSrc),  32'(r.alusrc));
    if ((r.care & CARE_ALU) != 0)  checkOutput({p, ".ALUOp"},   32'(ALUOp),   32'(r.aluop));
    if ((r.care & CARE_EXT) != 0)  checkOutput({p, ".ExtOp"},   32'(ExtOp),   32'(r.extop));
    if ((r.care & CARE_NPC) != 0)  checkOutput({p, ".NPCOp"},   32'(NPCOp),   32'(r.npcop));
  endtask

  // Runs one instruction from FETCH; expLen < 0 takes the latency from the trace model
  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int waits, input int expLen);
    int cyc;
    bit done;
    bit isMem;
    buildTrace(op, fn, z, waits);
    if (expLen < 0) expLen = expQ.size();
    isMem = (op == 6'b100011 || op == 6'b101011);
    Op = op;
    Funct = fn;
    cyc = 0;
    done = 0;
    while (!done) begin
      mem_rdy = isMem ? (cyc >= 3 + waits) : 1'($urandom);
      zero = (cyc == 2) ? z : 1'($urandom);
      #1;
      if (cyc < expQ.size()) compareRec(name, cyc, expQ[cyc]);
      @(posedge clk); #1;
      cyc++;
      if (state_o == 4'd0 || state_o == 4'd15 || cyc >= 64) done = 1;
    end
    checkOutput({name, ".latency"}, 32'(cyc), 32'(expLen));
    if (expIll) begin
      checkOutput({name, ".ill_state"}, 32'(state_o), 32'd15);
      checkOutput({name, ".illegal"}, 32'(illegal), 32'd1);
      checkOutput({name, ".err_code"}, 32'(err_code), 32'(expErr));
    end else begin
      modelCnt++;
      checkOutput({name, ".end_state"}, 32'(state_o), 32'd0);
    end
    checkOutput({name, ".instr_cnt"}, 32'(instr_cnt), 32'(modelCnt));
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    checkOutput("reset.strobes_now", 32'({PCWr, IRWr, RegW, MemR, MemW}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("reset.strobes_c%0d", i), 32'({PCWr, IRWr, RegW, MemR, MemW}), 32'd0);
    end
    rst = 1'b1;
    #1;
    modelCnt = 0;
    checkOutput("reset.state", 32'(state_o), 32'd0);
    checkOutput("reset.IRWr", 32'(IRWr), 32'd1);
    checkOutput("reset.instr_cnt", 32'(instr_cnt), 32'd0);
    checkOutput("reset.illegal", 32'(illegal), 32'd0);
    checkOutput("reset.err_code", 32'(err_code), 32'd0);
  endtask

  task automatic holdIll(input string name, input logic [1:0] err);
    for (int i = 0; i < 20; i++) begin
      mem_rdy = 1'($urandom);
      zero = 1'($urandom);
      #1;
      checkOutput($sformatf("%s.hold%0d.state", name, i), 32'(state_o), 32'd15);
      checkOutput($sformatf("%s.hold%0d.strobes", name, i), 32'({PCWr, IRWr, RegW, MemR, MemW}), 32'd0);
      checkOutput($sformatf("%s.hold%0d.err", name, i), 32'({illegal, err_code}), 32'({1'b1, err}));
      @(posedge clk); #1;
    end
    doReset();
  endtask

  task automatic addVec(input string n, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int w, input int c);
    vec_t v;
    v.name = n; v.op = op; v.funct = fn; v.z = z; v.waits = w; v.exp_cycles = c;
    vecs.push_back(v);
  endtask

  logic [5:0] poolOp[11] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001001,
                             6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  logic [5:0] poolFn[4]  = '{6'b100001, 6'b100011, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    int idx, waits;

    rst = 1'b0; Op = '0; Funct = '0; zero = 1'b0; mem_rdy = 1'b0;
    @(posedge clk); #1;
    doReset();

    addVec("addu",     6'b000000, 6'b100001, 1'b0, 0, 4);
    addVec("subu",     6'b000000, 6'b100011, 1'b1, 0, 4);
    addVec("or",       6'b000000, 6'b100101, 1'b0, 0, 4);
    addVec("slt",      6'b000000, 6'b101010, 1'b1, 0, 4);
    addVec("ori",      6'b001101, 6'b010101, 1'b0, 0, 4);
    addVec("addiu",    6'b001001, 6'b111000, 1'b0, 0, 4);
    addVec("lui",      6'b001111, 6'b000111, 1'b0, 0, 4);
    addVec("lw",       6'b100011, 6'b000000, 1'b0, 0, 5);
    addVec("sw",       6'b101011, 6'b000000, 1'b0, 0, 4);
    addVec("lw_wait3", 6'b100011, 6'b000000, 1'b0, 3, 8);
    addVec("sw_wmax",  6'b101011, 6'b000000, 1'b0, WAIT_MAX, 4 + WAIT_MAX);
    addVec("beq_z1",   6'b000100, 6'b000000, 1'b1, 0, 3);
    addVec("beq_z0",   6'b000100, 6'b000000, 1'b0, 0, 3);
    addVec("j",        6'b000010, 6'b101010, 1'b0, 0, 3);
    addVec("bad_fn",   6'b000000, 6'b000000, 1'b0, 0, 2);
    addVec("bad_op",   6'b111111, 6'b100001, 1'b0, 0, 2);
    addVec("sw_tmo",   6'b101011, 6'b000000, 1'b0, 1000, 3 + WAIT_MAX + 1);
    addVec("lw_tmo",   6'b100011, 6'b000000, 1'b0, 1000, 3 + WAIT_MAX + 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].waits, vecs[i].exp_cycles);
      if (expIll) holdIll(vecs[i].name, expErr);
    end

    // Reset arriving while a load is stalled in MRD
    Op = 6'b100011; Funct = '0; mem_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("midreset.state", 32'(state_o), 32'd3);
    checkOutput("midreset.MemR", 32'(MemR), 32'd1);
    doReset();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        idx = $urandom_range(0, 10);
        op = poolOp[idx];
        fn = (idx < 4) ? poolFn[idx] : 6'($urandom);
      end
      waits = ($urandom_range(0, 39) == 0) ? WAIT_MAX + 5 : $urandom_range(0, 4);
      applyStimulus($sformatf("rnd%0d", n), op, fn, 1'($urandom), waits, -1);
      if (expIll) holdIll($sformatf("rnd%0d", n), expErr);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
